mc_controller: RTL and testbench
================================

# mc_controller

Parametrised multicycle control unit for the ARM-subset datapath, successor to the fixed two-bit controller. It decodes `Instr[31:12]`, sequences the multicycle datapath through a Moore FSM and keeps the NZCV flags with conditional-execution logic. Over the fixed controller it adds a configurable ALU-control width (EOR when wide), flag-only CMP, and an optional memory wait-state handshake. It sits between the instruction register and the datapath mux/enable controls.

## Interface
- `ALUCTRL_W`, default 2: ALUControl width.
  - Legal values are 2 or 3.
  - 3 enables EOR.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `Instr` in [31:12]: {Cond, Op, Funct, Rd}.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU, current cycle.
- `MemReady` in 1: memory access complete. Ignored unless `MC_CTRL_MEMWAIT_EN` is defined.
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite` out 1: datapath write enables.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `RegSrc` out 2:
  - [0] = read PC (branch).
  - [1] = read Rd as source (STR).
- `ALUSrcA` out 2: 00 = RD1, 01 = PC, 10 = ALUOut.
- `ALUSrcB` out 2: 00 = RD2, 01 = ExtImm, 10 = const 4.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ImmSrc` out 2: equals `Instr[27:26]`.
- `ALUControl` out `ALUCTRL_W`: 0 = ADD, 1 = SUB, 2 = AND, 3 = ORR, 4 = EOR (3-bit only).
- `Flags` out 4: registered NZCV (debug/visibility).

## Operation
- FSM states:
  - FETCH: AdrSrc=0, IRWrite, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, PCWrite. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Latches CondExR. Next, by Op:
    - Op=01 → MEMADR.
    - Op=00, Funct[5]=0 → EXECR.
    - Op=00, Funct[5]=1 → EXECI.
    - Op=10 → BRANCH.
    - Op=11 → FETCH, with no writes.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Next: MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD: AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=CondExR. Next: FETCH.
  - MEMWR: AdrSrc=1, MemWrite=CondExR. Next: FETCH.
  - EXECR: ALUSrcA=00, ALUSrcB=00, ALU op from Funct[4:1]. Next: ALUWB.
  - EXECI: same as EXECR but ALUSrcB=01. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=CondExR & ~NoWrite. Next: FETCH.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExR. Next: FETCH.
- ALU decode from Funct[4:1]:
  - 0100 → ADD; 0010 → SUB; 0000 → AND; 1100 → ORR.
  - 1010 (CMP) → SUB with NoWrite=1 and flags written regardless of S.
  - 0001 (EOR) → EOR when `ALUCTRL_W`=3. When `ALUCTRL_W`=2 it is unsupported.
  - Any unsupported cmd → ADD, NoWrite=1, no flag write.
- Flag write happens at the EXECR/EXECI clock edge when CondExR & (S | CMP):
  - N and Z always update.
  - C and V update only for ADD/SUB/CMP.
- CondEx uses the standard ARM cond table (EQ…AL) on the registered Flags. Cond=1111 evaluates false.
- RegSrc[0] = (Op==10). RegSrc[1] = (Op==01 & ~Funct[0]). Both are combinational from Instr.

## Timing
- Reset (asserted low, asynchronous):
  - State=FETCH, Flags=0000, CondExR=0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced 0 while reset is low.
  - All other outputs take their FETCH values.
- Cycle counts: LDR = 5, STR = 4, data-processing = 4, branch = 3, undefined = 2 cycles.
- A CondEx false result suppresses only the write enables. The state path is unchanged.
- Flags written in EXECR/EXECI are visible to the next instruction's DECODE.
- Reset deassertion mid-instruction restarts at FETCH. No partial writes occur.

## Configuration
- `MC_CTRL_MEMWAIT_EN` defined:
  - FETCH, MEMRD and MEMWR hold while MemReady=0.
  - IRWrite and PCWrite in FETCH are qualified by MemReady.
  - MemWrite stays asserted until MemReady=1; the state advances on that cycle.
- `MC_CTRL_MEMWAIT_EN` undefined: MemReady is ignored and treated as 1.

## Structure
- `mc_ctrl_pkg` holds:
  - the state enum `mc_state_t`;
  - the ALU op constants (`ALU_ADD` … `ALU_EOR`);
  - the cond-code constants;
  - the mux-select constants.
- Sub-module `mc_condlogic` contains the Flags register, the CondEx evaluation, CondExR and the flag-write gating.

## Test plan
- Reset low mid-MEMWB, then release:
  - State goes to FETCH and Flags to 0000.
  - No RegWrite during reset.
  - IRWrite=1 on the first cycle after release.
- ADD R1 (E0811002), then SUB imm setting flags with ALUFlags=0100:
  - Each instruction takes 4 cycles.
  - ALUControl=0 then 1.
  - Flags=0100 after EXECI.
- BEQ with Z=1 → PCWrite=1 in BRANCH. BNE with Z=1 → PCWrite=0 and FETCH follows.
- LDR (E5912004) → MEMRD then MEMWB with ResultSrc=01 and RegWrite=1. STR (E5812004) → MemWrite=1, RegSrc=10.
- CMP sets Z with RegWrite=0. EOR with `ALUCTRL_W`=3 gives ALUControl=4; with `ALUCTRL_W`=2 it gives no write.
- With `MC_CTRL_MEMWAIT_EN` and MemReady low for 3 cycles in MEMWR:
  - MemWrite is held for 4 cycles.
  - FETCH starts after MemReady=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, ALU-op, cond-code and mux-select constants for mc_controller
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } mc_state_t;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                         ALU_ORR = 3'd3, ALU_EOR = 3'd4;

  localparam logic [3:0] CMD_AND = 4'b0000, CMD_EOR = 4'b0001, CMD_SUB = 4'b0010,
                         CMD_ADD = 4'b0100, CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                         COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                         COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                         COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam logic [1:0] SRCA_RD1 = 2'b00, SRCA_PC = 2'b01;
  localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = ~c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = ~n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = ~v;
      COND_HI: cond_eval = c & ~z;
      COND_LS: cond_eval = ~c | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = ~z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      COND_NV: cond_eval = 1'b0;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - instruction/flag inputs and datapath controls of mc_controller
interface mc_controller_if #(parameter int ALUCTRL_W = 2);
  logic [31:12]         Instr;
  logic [3:0]           ALUFlags;
  logic                 MemReady;
  logic                 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]           RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [3:0]           Flags;

  modport master (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Flags
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Flags
  );
endinterface

// File: rtl/mc_condlogic.sv
// rtl/mc_condlogic.sv - NZCV register, condition evaluation and registered CondEx
module mc_condlogic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_latch,
  input  logic       flag_wr,
  input  logic       cv_wr,
  output logic [3:0] flags,
  output logic       cond_ex_r
);

  logic cond_ex;
  assign cond_ex = cond_eval(cond, flags);

  // C and V only follow the ALU for arithmetic ops; logical ops keep them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags     <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      if (cond_latch) cond_ex_r <= cond_ex;
      if (flag_wr && cond_ex_r) begin
        flags[3:2] <= alu_flags[3:2];
        if (cv_wr) flags[1:0] <= alu_flags[1:0];
      end
    end
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle ARM-subset control FSM; MC_CTRL_MEMWAIT_EN adds memory wait states
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 2
) (
  input logic             clk,
  input logic             reset,
  mc_controller_if.master bus
);

  mc_state_t  state, next_state;
  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       funct5, funct0, mem_ready;
  logic [2:0] alu_op, alu_sel;
  logic       no_write, is_cmp, cv_op, supported, in_exec, cond_ex_r;
  logic       pc_write, mem_write, reg_write, ir_write;
  logic       unused_ok;

  assign cond   = bus.Instr[31:28];
  assign op     = bus.Instr[27:26];
  assign funct5 = bus.Instr[25];
  assign cmd    = bus.Instr[24:21];
  assign funct0 = bus.Instr[20];

`ifdef MC_CTRL_MEMWAIT_EN
  assign mem_ready = bus.MemReady;
  assign unused_ok = &{1'b0, bus.Instr[19:12], alu_sel};
`else
  assign mem_ready = 1'b1;
  assign unused_ok = &{1'b0, bus.Instr[19:12], alu_sel, bus.MemReady};
`endif

  // Unsupported commands fall back to ADD with neither register nor flag write
  always_comb begin
    alu_op = ALU_ADD; no_write = 1'b1; is_cmp = 1'b0; cv_op = 1'b0; supported = 1'b0;
    case (cmd)
      CMD_ADD: begin no_write = 1'b0; supported = 1'b1; cv_op = 1'b1; end
      CMD_SUB: begin alu_op = ALU_SUB; no_write = 1'b0; supported = 1'b1; cv_op = 1'b1; end
      CMD_AND: begin alu_op = ALU_AND; no_write = 1'b0; supported = 1'b1; end
      CMD_ORR: begin alu_op = ALU_ORR; no_write = 1'b0; supported = 1'b1; end
      CMD_CMP: begin alu_op = ALU_SUB; is_cmp = 1'b1; supported = 1'b1; cv_op = 1'b1; end
      CMD_EOR: if (ALUCTRL_W == 3) begin
        alu_op = ALU_EOR; no_write = 1'b0; supported = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_exec = (state == S_EXECR) || (state == S_EXECI);

  mc_condlogic u_condlogic (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (bus.ALUFlags),
    .cond_latch(state == S_DECODE),
    .flag_wr   (in_exec && supported && (funct0 || is_cmp)),
    .cv_wr     (cv_op),
    .flags     (bus.Flags),
    .cond_ex_r (cond_ex_r)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   next_state = S_MEMADR;
          2'b00:   next_state = funct5 ? S_EXECI : S_EXECR;
          2'b10:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = funct0 ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWR:  if (mem_ready) next_state = S_FETCH;
      S_EXECR, S_EXECI: next_state = S_ALUWB;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write = 1'b0; mem_write = 1'b0; reg_write = 1'b0; ir_write = 1'b0;
    bus.AdrSrc = 1'b0; bus.ALUSrcA = SRCA_RD1; bus.ALUSrcB = SRCB_RD2;
    bus.ResultSrc = RES_ALUOUT; alu_sel = ALU_ADD;
    case (state)
      S_FETCH: begin
        ir_write = mem_ready; pc_write = mem_ready;
        bus.ALUSrcA = SRCA_PC; bus.ALUSrcB = SRCB_FOUR; bus.ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_PC; bus.ALUSrcB = SRCB_FOUR; bus.ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: bus.ALUSrcB = SRCB_IMM;
      S_MEMRD:  bus.AdrSrc = 1'b1;
      S_MEMWB:  begin bus.ResultSrc = RES_DATA; reg_write = cond_ex_r; end
      S_MEMWR:  begin bus.AdrSrc = 1'b1; mem_write = cond_ex_r; end
      S_EXECR:  alu_sel = alu_op;
      S_EXECI:  begin bus.ALUSrcB = SRCB_IMM; alu_sel = alu_op; end
      S_ALUWB:  reg_write = cond_ex_r & ~no_write;
      S_BRANCH: begin
        bus.ALUSrcB = SRCB_IMM; bus.ResultSrc = RES_ALURESULT; pc_write = cond_ex_r;
      end
      default: ;
    endcase
  end

  // Write enables are held off for the whole time reset is low
  assign bus.PCWrite    = pc_write & reset;
  assign bus.IRWrite    = ir_write & reset;
  assign bus.MemWrite   = mem_write & reset;
  assign bus.RegWrite   = reg_write & reset;
  assign bus.ALUControl = alu_sel[ALUCTRL_W-1:0];
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == 2'b01) && !funct0, op == 2'b10};

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - table/scoreboard bench for mc_controller; honours MC_CTRL_MEMWAIT_EN
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_word;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  int          checks = 0;
  int          errors = 0;

`ifdef MC_CTRL_MEMWAIT_EN
  localparam int   HOLD    = 3;
  localparam logic MR_LAST = 1'b1;
`else
  localparam int   HOLD    = 0;
  localparam logic MR_LAST = 1'b0;
`endif

  always #5 clk = ~clk;

  mc_controller_if #(.ALUCTRL_W(2)) bus2 ();
  mc_controller_if #(.ALUCTRL_W(3)) bus3 ();

  assign bus2.Instr    = instr_word[31:12];
  assign bus2.ALUFlags = alu_flags;
  assign bus2.MemReady = mem_ready;
  assign bus3.Instr    = instr_word[31:12];
  assign bus3.ALUFlags = alu_flags;
  assign bus3.MemReady = mem_ready;

  mc_controller #(.ALUCTRL_W(2)) dut  (.clk(clk), .reset(reset), .bus(bus2));
  mc_controller #(.ALUCTRL_W(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  aflags;
    int          cycles;
    logic [7:0]  pcw, regw2, regw3, memw, adr;
    logic [1:0]  regsrc;
    logic [2:0]  alu2, alu3;
    logic [3:0]  flags2, flags3;
  } vec_t;

  typedef struct {
    string      name;
    int         cyc;
    logic       irw, pcw, regw2, regw3, memw, adr;
    logic [1:0] regsrc;
    logic       chk_alu;
    logic [2:0] alu2, alu3;
    logic       chk_flags;
    logic [3:0] flags2, flags3;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[17];

  task automatic check(input string what, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      string t;
      e = sb.pop_front();
      t = $sformatf("%s c%0d", e.name, e.cyc);
      check({t, " IRWrite"},  8'(bus2.IRWrite),  8'(e.irw));
      check({t, " PCWrite"},  8'(bus2.PCWrite),  8'(e.pcw));
      check({t, " RegWrite"}, 8'(bus2.RegWrite), 8'(e.regw2));
      check({t, " RegWrite3"}, 8'(bus3.RegWrite), 8'(e.regw3));
      check({t, " MemWrite"}, 8'(bus2.MemWrite), 8'(e.memw));
      check({t, " AdrSrc"},   8'(bus2.AdrSrc),   8'(e.adr));
      check({t, " RegSrc"},   8'(bus2.RegSrc),   8'(e.regsrc));
      if (e.chk_alu) begin
        check({t, " ALUControl"},  8'(bus2.ALUControl), 8'(e.alu2));
        check({t, " ALUControl3"}, 8'(bus3.ALUControl), 8'(e.alu3));
      end
      if (e.chk_flags) begin
        check({t, " Flags"},  8'(bus2.Flags), 8'(e.flags2));
        check({t, " Flags3"}, 8'(bus3.Flags), 8'(e.flags3));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    instr_word = v.instr;
    alu_flags  = v.aflags;
`ifndef MC_CTRL_MEMWAIT_EN
    mem_ready  = 1'($urandom_range(0, 1));
`endif
    for (int c = 0; c < v.cycles; c++) begin
      exp_t e;
      e.name      = v.name;
      e.cyc       = c;
      e.irw       = (c == 0);
      e.pcw       = v.pcw[c];
      e.regw2     = v.regw2[c];
      e.regw3     = v.regw3[c];
      e.memw      = v.memw[c];
      e.adr       = v.adr[c];
      e.regsrc    = v.regsrc;
      e.chk_alu   = (c == 0) || (c == 2);
      e.alu2      = (c == 2) ? v.alu2 : 3'd0;
      e.alu3      = (c == 2) ? v.alu3 : 3'd0;
      e.chk_flags = (c == v.cycles - 1);
      e.flags2    = v.flags2;
      e.flags3    = v.flags3;
      sb.push_back(e);
    end
    repeat (v.cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //           name        instr         aflag   cyc pcw    regw2  regw3  memw   adr    rsrc   alu2  alu3  flags2   flags3
    vecs[0]  = '{"add",      32'hE0811002, 4'b0100, 4, 8'h01, 8'h08, 8'h08, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0, 4'b0000, 4'b0000};
    vecs[1]  = '{"subs_imm", 32'hE2511001, 4'b0100, 4, 8'h01, 8'h08, 8'h08, 8'h00, 8'h00, 2'b00, 3'd1, 3'd1, 4'b0100, 4'b0100};
    vecs[2]  = '{"beq",      32'h0A000002, 4'b0000, 3, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 3'd0, 3'd0, 4'b0100, 4'b0100};
    vecs[3]  = '{"bne",      32'h1A000002, 4'b0000, 3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 3'd0, 3'd0, 4'b0100, 4'b0100};
    vecs[4]  = '{"ldr",      32'hE5912004, 4'b0000, 5, 8'h01, 8'h10, 8'h10, 8'h00, 8'h08, 2'b00, 3'd0, 3'd0, 4'b0100, 4'b0100};
    vecs[5]  = '{"str",      32'hE5812004, 4'b0000, 4, 8'h01, 8'h00, 8'h00, 8'h08, 8'h08, 2'b10, 3'd0, 3'd0, 4'b0100, 4'b0100};
    vecs[6]  = '{"cmp_nos",  32'hE1410002, 4'b0110, 4, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 3'd1, 3'd1, 4'b0110, 4'b0110};
    vecs[7]  = '{"ands",     32'hE0111002, 4'b1011, 4, 8'h01, 8'h08, 8'h08, 8'h00, 8'h00, 2'b00, 3'd2, 3'd2, 4'b1010, 4'b1010};
    vecs[8]  = '{"orr",      32'hE1811002, 4'b0000, 4, 8'h01, 8'h08, 8'h08, 8'h00, 8'h00, 2'b00, 3'd3, 3'd3, 4'b1010, 4'b1010};
    vecs[9]  = '{"eors",     32'hE0311002, 4'b0101, 4, 8'h01, 8'h00, 8'h08, 8'h00, 8'h00, 2'b00, 3'd0, 3'd4, 4'b1010, 4'b0110};
    vecs[10] = '{"addseq",   32'h00911002, 4'b1111, 4, 8'h01, 8'h00, 8'h08, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0, 4'b1010, 4'b1111};
    vecs[11] = '{"undef",    32'hEC000000, 4'b0000, 2, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0, 4'b1010, 4'b1111};
    vecs[12] = '{"addnv",    32'hF0811002, 4'b0000, 4, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0, 4'b1010, 4'b1111};
    vecs[13] = '{"rsb_unsup", 32'hE0611002, 4'b0000, 4, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0, 4'b1010, 4'b1111};
    vecs[14] = '{"cmps",     32'hE1510002, 4'b0100, 4, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 3'd1, 3'd1, 4'b0100, 4'b0100};
    vecs[15] = '{"blt",      32'hBA000002, 4'b0000, 3, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 3'd0, 3'd0, 4'b0100, 4'b0100};
    vecs[16] = '{"bge",      32'hAA000002, 4'b0000, 3, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 3'd0, 3'd0, 4'b0100, 4'b0100};

    reset = 1'b0; instr_word = 32'hE0811002; alu_flags = 4'h0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst IRWrite",   8'(bus2.IRWrite),   8'h0);
    check("rst PCWrite",   8'(bus2.PCWrite),   8'h0);
    check("rst RegWrite",  8'(bus2.RegWrite),  8'h0);
    check("rst MemWrite",  8'(bus2.MemWrite),  8'h0);
    check("rst Flags",     8'(bus2.Flags),     8'h0);
    check("rst ResultSrc", 8'(bus2.ResultSrc), 8'h2);
    check("rst ALUSrcA",   8'(bus2.ALUSrcA),   8'h1);
    check("rst ALUSrcB",   8'(bus2.ALUSrcB),   8'h2);
    check("rst AdrSrc",    8'(bus2.AdrSrc),    8'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // LDR interrupted by reset in MEMWB
    instr_word = 32'hE5912004; alu_flags = 4'h0; mem_ready = 1'b1;
    @(negedge clk);
    check("ldr2 fetch IRWrite", 8'(bus2.IRWrite), 8'h1);
    step(); step();
    @(negedge clk);
    check("ldr2 memadr ALUSrcB", 8'(bus2.ALUSrcB), 8'h1);
    step();
    @(negedge clk);
    check("ldr2 memrd AdrSrc", 8'(bus2.AdrSrc), 8'h1);
    step();
    @(negedge clk);
    check("ldr2 memwb ResultSrc", 8'(bus2.ResultSrc), 8'h1);
    check("ldr2 memwb RegWrite",  8'(bus2.RegWrite),  8'h1);
    #1 reset = 1'b0;
    #1;
    check("midrst RegWrite",  8'(bus2.RegWrite),  8'h0);
    check("midrst Flags",     8'(bus2.Flags),     8'h0);
    check("midrst ResultSrc", 8'(bus2.ResultSrc), 8'h2);
    @(posedge clk);
    @(negedge clk);
    check("midrst IRWrite", 8'(bus2.IRWrite), 8'h0);
    check("midrst PCWrite", 8'(bus2.PCWrite), 8'h0);
    reset = 1'b1;
    #1;
    check("release IRWrite", 8'(bus2.IRWrite), 8'h1);
    check("release PCWrite", 8'(bus2.PCWrite), 8'h1);
    @(posedge clk);
    #1;
    repeat (4) step();

    // STR with MemReady low in MEMWR
    instr_word = 32'hE5812004; mem_ready = 1'b1;
    repeat (3) step();
    mem_ready = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      check($sformatf("memwr hold%0d MemWrite", i), 8'(bus2.MemWrite), 8'h1);
      check($sformatf("memwr hold%0d IRWrite", i),  8'(bus2.IRWrite),  8'h0);
      step();
    end
    mem_ready = MR_LAST;
    @(negedge clk);
    check("memwr last MemWrite", 8'(bus2.MemWrite), 8'h1);
    step();
    @(negedge clk);
    check("memwr then IRWrite",  8'(bus2.IRWrite),  8'h1);
    check("memwr then MemWrite", 8'(bus2.MemWrite), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
